// File: rtl/anti_theft_pkg.sv
// Shared state and time-register select encodings
// for the anti-theft arming/alarm controller.
package anti_theft_pkg;

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGER    = 3'd1,
    ALARM      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DLY    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    SEL_ARM   = 2'd0,
    SEL_DRV   = 2'd1,
    SEL_PAS   = 2'd2,
    SEL_ALARM = 2'd3
  } sel_e;

endpackage

// File: rtl/anti_theft_fsm_alarm_timer.sv
// Loadable down-counter; expires when a tick
// arrives while the count is at one.
module alarm_timer #(
  parameter int TW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  input  logic          hold,
  output logic          expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && !hold && cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // A load in the same cycle always wins; callers never
  // consume expiry on a cycle where they also load.
  assign expired = tick && !hold && (cnt_q == TW'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft arming/alarm controller.
// Define STATUS_BLINK_EN for a blinking LED while armed.
module anti_theft_fsm
  import anti_theft_pkg::*;
#(
  parameter int T_ARM_DEF   = 6,
  parameter int T_DRV_DEF   = 8,
  parameter int T_PAS_DEF   = 15,
  parameter int T_ALARM_DEF = 10,
  parameter int TW          = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          one_hz_en,
  input  logic          ignition,
  input  logic          door_drv,
  input  logic          door_pas,
  input  logic          reprogram,
  input  logic [1:0]    time_sel,
  input  logic [TW-1:0] time_value,
  output logic          siren,
  output logic          status_led,
  output logic          armed,
  output logic [2:0]    state_dbg
);

  state_e        state_q, state_d;
  logic [TW-1:0] tm_q [4];
  logic          ld;
  logic [TW-1:0] ld_val;
  logic          hold;
  logic          expd;
  logic          any_door;
  logic          siren_q, led_q, armed_q;
  logic          led_d;

  assign any_door = door_drv | door_pas;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tm_q[SEL_ARM]   <= TW'(T_ARM_DEF);
      tm_q[SEL_DRV]   <= TW'(T_DRV_DEF);
      tm_q[SEL_PAS]   <= TW'(T_PAS_DEF);
      tm_q[SEL_ALARM] <= TW'(T_ALARM_DEF);
    end else if (reprogram) begin
      tm_q[time_sel] <= (time_value == '0) ?
                        TW'(1) : time_value;
    end
  end

  // Untimed states freeze the counter; depends on state only.
  assign hold = (state_q == ARMED)      ||
                (state_q == DISARMED)   ||
                (state_q == WAIT_OPEN)  ||
                (state_q == WAIT_CLOSE);

  alarm_timer #(.TW(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .tick     (one_hz_en),
    .hold     (hold),
    .expired  (expd)
  );

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = '0;
    case (state_q)
      ARMED: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (door_drv) begin
          state_d = TRIGGER;
          ld      = 1'b1;
          ld_val  = tm_q[SEL_DRV];
        end else if (door_pas) begin
          state_d = TRIGGER;
          ld      = 1'b1;
          ld_val  = tm_q[SEL_PAS];
        end
      end
      TRIGGER: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (expd) begin
          state_d = ALARM;
          ld      = 1'b1;
          ld_val  = tm_q[SEL_ALARM];
        end
      end
      ALARM: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (any_door) begin
          ld      = 1'b1;
          ld_val  = tm_q[SEL_ALARM];
        end else if (expd) begin
          state_d = ARMED;
        end
      end
      DISARMED: begin
        if (!ignition) state_d = WAIT_OPEN;
      end
      WAIT_OPEN: begin
        if (ignition)      state_d = DISARMED;
        else if (door_drv) state_d = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (!any_door) begin
          state_d = ARM_DLY;
          ld      = 1'b1;
          ld_val  = tm_q[SEL_ARM];
        end
      end
      ARM_DLY: begin
        if (ignition)      state_d = DISARMED;
        else if (any_door) state_d = WAIT_CLOSE;
        else if (expd)     state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
    if (reprogram) begin
      state_d = ARMED;
      ld      = 1'b1;
      ld_val  = '0;
    end
  end

`ifdef STATUS_BLINK_EN
  logic blink_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 blink_q <= 1'b0;
    else if (state_q != ARMED)  blink_q <= 1'b0;
    else if (one_hz_en)         blink_q <= ~blink_q;
  end
`endif

  always_comb begin
    led_d = 1'b0;
    unique case (1'b1)
      state_q == ARMED: begin
`ifdef STATUS_BLINK_EN
        led_d = blink_q;
`else
        led_d = 1'b1;
`endif
      end
      state_q == TRIGGER,
      state_q == ALARM: led_d = 1'b1;
      default:          led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARMED;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      siren_q <= (state_q == ALARM);
      led_q   <= led_d;
      armed_q <= (state_q == ARMED) || (state_q == TRIGGER);
    end
  end

  assign siren      = siren_q;
  assign status_led = led_q;
  assign armed      = armed_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed self-checking bench for anti_theft_fsm
// (default build, solid status LED while armed).
module tb_anti_theft_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en, ign, drv, pas, reprog;
  logic [1:0] sel;
  logic [3:0] tval;
  logic       siren, led, armed;
  logic [2:0] st;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  anti_theft_fsm dut (
    .clock      (clk),
    .reset      (rst_n),
    .one_hz_en  (tick_en),
    .ignition   (ign),
    .door_drv   (drv),
    .door_pas   (pas),
    .reprogram  (reprog),
    .time_sel   (sel),
    .time_value (tval),
    .siren      (siren),
    .status_led (led),
    .armed      (armed),
    .state_dbg  (st)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_en = 1'b1;
      @(negedge clk);
      tick_en = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick_en = 0; ign = 0; drv = 0;
    pas = 0; reprog = 0; sel = 0; tval = 0;
    cyc(2);
    check("rst_state", 8'(st), 8'd0);
    check("rst_armed", 8'(armed), 8'd1);
    check("rst_siren", 8'(siren), 8'd0);
    check("rst_led", 8'(led), 8'd0);
    rst_n = 1'b1;
    cyc(1);
    check("armed_led", 8'(led), 8'd1);

    // driver door -> trigger -> alarm -> re-armed
    drv = 1'b1; cyc(1); drv = 1'b0;
    check("drv_trig", 8'(st), 8'd1);
    ticks(7);
    check("drv_7t", 8'(st), 8'd1);
    ticks(1);
    check("drv_alarm", 8'(st), 8'd2);
    check("drv_siren", 8'(siren), 8'd1);
    ticks(9);
    check("alm_9t", 8'(st), 8'd2);
    ticks(1);
    check("alm_rearm", 8'(st), 8'd0);
    check("alm_siren0", 8'(siren), 8'd0);

    // passenger door, disarmed by ignition mid-countdown
    pas = 1'b1; cyc(1); pas = 1'b0;
    check("pas_trig", 8'(st), 8'd1);
    ticks(5);
    ign = 1'b1; cyc(1);
    check("pas_dis", 8'(st), 8'd3);
    check("pas_armlag", 8'(armed), 8'd1);
    cyc(1);
    check("pas_arm0", 8'(armed), 8'd0);
    check("pas_nosiren", 8'(siren), 8'd0);

    // arming sequence with reopen during delay
    ign = 1'b0; cyc(1);
    check("wopen", 8'(st), 8'd4);
    drv = 1'b1; cyc(1);
    check("wclose", 8'(st), 8'd5);
    drv = 1'b0; cyc(1);
    check("armdly", 8'(st), 8'd6);
    ticks(3);
    drv = 1'b1; cyc(1);
    check("reopen", 8'(st), 8'd5);
    drv = 1'b0; cyc(1);
    check("armdly2", 8'(st), 8'd6);
    ticks(5);
    check("armdly_5t", 8'(st), 8'd6);
    ticks(1);
    check("armed_again", 8'(st), 8'd0);
    cyc(1);
    check("armed_flag", 8'(armed), 8'd1);

    // reprogram DRV=0 (stored as 1) wins over WAIT_OPEN move
    ign = 1'b1; cyc(1);
    check("dis2", 8'(st), 8'd3);
    ign = 1'b0; reprog = 1'b1; sel = 2'd1; tval = 4'd0;
    cyc(1);
    reprog = 1'b0;
    check("reprog_armed", 8'(st), 8'd0);
    drv = 1'b1; cyc(1); drv = 1'b0;
    check("rp_trig", 8'(st), 8'd1);
    ticks(1);
    check("rp_alarm", 8'(st), 8'd2);
    check("rp_siren", 8'(siren), 8'd1);

    // door held open keeps alarm going
    pas = 1'b1;
    ticks(20);
    check("hold_st", 8'(st), 8'd2);
    check("hold_siren", 8'(siren), 8'd1);
    pas = 1'b0;
    ticks(9);
    check("hold_9t", 8'(siren), 8'd1);
    ticks(1);
    check("hold_clr", 8'(siren), 8'd0);
    check("hold_armed", 8'(st), 8'd0);

    // reset during a held alarm restores defaults
    drv = 1'b1; cyc(1); drv = 1'b0;
    ticks(1);
    check("r_alarm", 8'(st), 8'd2);
    pas = 1'b1;
    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_st", 8'(st), 8'd0);
    check("async_siren", 8'(siren), 8'd0);
    check("async_armed", 8'(armed), 8'd1);
    @(negedge clk);
    rst_n = 1'b1; pas = 1'b0;
    cyc(1);
    // load and tick together: load wins, full 8 ticks remain
    drv = 1'b1; tick_en = 1'b1; cyc(1);
    drv = 1'b0; tick_en = 1'b0;
    check("def_trig", 8'(st), 8'd1);
    cyc(1);
    ticks(7);
    check("def_7t", 8'(st), 8'd1);
    ticks(1);
    check("def_alarm", 8'(st), 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
